alu_arb2: RTL and testbench

Two-port arbiter and sequencer for the shared 4-bit ALU/accumulator (`accum5`). It accepts operation requests (operands `a`, `b`, opcode `m`, `cin`) from two independent requesters and grants the ALU to one at a time in round-robin order. It holds the operands stable for the ALU's registered latency, captures the result and overflow flag, and returns them with a one-cycle done pulse. It sits between the two requesting controllers and the ALU, and shares the ALU's clock and reset.

---
 rtl/alu_arb2.sv | 161 ++++++++++++++++
 tb/tb_alu_arb2.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arb2.sv
// Round-robin arbiter/sequencer sharing one registered-latency ALU between two requesters.
// Latches the winner's operands, waits ALU_LAT edges, captures result and pulses that port's done.
module alu_arb2 #(
    parameter int W       = 4,
    parameter int OPW     = 4,
    parameter int ALU_LAT = 1
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_req0,
    input  logic           i_req1,
    input  logic [W-1:0]   i_a0,
    input  logic [W-1:0]   i_b0,
    input  logic [OPW-1:0] i_m0,
    input  logic           i_cin0,
    input  logic [W-1:0]   i_a1,
    input  logic [W-1:0]   i_b1,
    input  logic [OPW-1:0] i_m1,
    input  logic           i_cin1,
    output logic           o_done0,
    output logic           o_done1,
    output logic [W-1:0]   o_res,
    output logic           o_res_of,
    output logic           o_busy,
    output logic           o_owner,
    output logic [W-1:0]   o_alu_a,
    output logic [W-1:0]   o_alu_b,
    output logic [OPW-1:0] o_alu_m,
    output logic           o_alu_cin,
    input  logic [W-1:0]   i_alu_r,
    input  logic           i_alu_of
);

    // state  | meaning
    // IDLE   | arbitrate; grant latches operands and loads cnt
    // RUN    | operands applied to ALU; cnt counts down to 1
    // SAMPLE | alu_r/alu_of valid; captured on leaving
    // DONE   | done pulse for owner
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam int CNT_W = 3;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_last;
    logic             r_owner;
    logic [W-1:0]     r_alu_a;
    logic [W-1:0]     r_alu_b;
    logic [OPW-1:0]   r_alu_m;
    logic             r_alu_cin;
    logic [W-1:0]     r_res;
    logic             r_res_of;
    logic             r_done0;
    logic             r_done1;

    logic             w_any_req;
    logic             w_grant_port;
    logic             w_grant;
    logic             w_capture;
    logic             w_cnt_dec;
    logic             w_busy;

    assign w_any_req    = i_req0 | i_req1;
    // On a tie the port that did not win last time gets the ALU.
    assign w_grant_port = (i_req0 & i_req1) ? ~r_last : i_req1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_any_req) w_state_nxt = S_RUN;
            S_RUN:    if (r_cnt == CNT_W'(1)) w_state_nxt = S_SAMPLE;
            S_SAMPLE: w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy    = 1'b1;
        w_grant   = 1'b0;
        w_capture = 1'b0;
        w_cnt_dec = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy  = 1'b0;
                w_grant = w_any_req;
            end
            S_RUN:    w_cnt_dec = 1'b1;
            S_SAMPLE: w_capture = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt     <= '0;
            r_last    <= 1'b1;
            r_owner   <= 1'b0;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_m   <= '0;
            r_alu_cin <= 1'b0;
        end else begin
            if (w_grant) begin
                r_cnt     <= CNT_W'(ALU_LAT);
                r_owner   <= w_grant_port;
                r_alu_a   <= w_grant_port ? i_a1   : i_a0;
                r_alu_b   <= w_grant_port ? i_b1   : i_b0;
                r_alu_m   <= w_grant_port ? i_m1   : i_m0;
                r_alu_cin <= w_grant_port ? i_cin1 : i_cin0;
            end else if (w_cnt_dec && r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_capture) begin
                r_last <= r_owner;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_res    <= '0;
            r_res_of <= 1'b0;
            r_done0  <= 1'b0;
            r_done1  <= 1'b0;
        end else begin
            if (w_capture) begin
                r_res    <= i_alu_r;
                r_res_of <= i_alu_of;
            end
            r_done0 <= w_capture & ~r_owner;
            r_done1 <= w_capture &  r_owner;
        end
    end

    assign o_done0   = r_done0;
    assign o_done1   = r_done1;
    assign o_res     = r_res;
    assign o_res_of  = r_res_of;
    assign o_busy    = w_busy;
    assign o_owner   = r_owner;
    assign o_alu_a   = r_alu_a;
    assign o_alu_b   = r_alu_b;
    assign o_alu_m   = r_alu_m;
    assign o_alu_cin = r_alu_cin;

endmodule

// File: tb/tb_alu_arb2.sv
// Bench for alu_arb2: two instances (ALU_LAT=1 and 3), each with a pipelined bench ALU,
// a transaction-level expected-output model checked every cycle, and directed literal checks.
module tb_alu_arb2;

    localparam int W   = 4;
    localparam int OPW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic           rst_n [2];
    logic           req0 [2], req1 [2], cin0 [2], cin1 [2];
    logic [W-1:0]   a0 [2], b0 [2], a1 [2], b1 [2];
    logic [OPW-1:0] m0 [2], m1 [2];
    logic           done0 [2], done1 [2], res_of [2], busy [2], owner [2], alu_cin [2];
    logic [W-1:0]   res [2], alu_a [2], alu_b [2];
    logic [OPW-1:0] alu_m [2];

    int checks = 0;
    int errors = 0;

    // Stand-in ALU function: {overflow, result}
    function automatic logic [W:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [OPW-1:0] m, input logic cin);
        logic [W:0] r;
        case (m)
            4'd0:    r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            4'd1:    r = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cin};
            4'd2:    r = {1'b0, a | b};
            4'd3:    r = {1'b0, a & b};
            default: r = {^m, a ^ b};
        endcase
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    for (genvar k = 0; k < 2; k++) begin : g_inst
        localparam int LAT = (k == 0) ? 1 : 3;

        logic [W:0]   pipe [LAT];
        logic [W-1:0] w_alu_r;
        logic         w_alu_of;

        alu_arb2 #(.W(W), .OPW(OPW), .ALU_LAT(LAT)) u_dut (
            .i_clk     (clk),
            .i_rst_n   (rst_n[k]),
            .i_req0    (req0[k]),
            .i_req1    (req1[k]),
            .i_a0      (a0[k]),
            .i_b0      (b0[k]),
            .i_m0      (m0[k]),
            .i_cin0    (cin0[k]),
            .i_a1      (a1[k]),
            .i_b1      (b1[k]),
            .i_m1      (m1[k]),
            .i_cin1    (cin1[k]),
            .o_done0   (done0[k]),
            .o_done1   (done1[k]),
            .o_res     (res[k]),
            .o_res_of  (res_of[k]),
            .o_busy    (busy[k]),
            .o_owner   (owner[k]),
            .o_alu_a   (alu_a[k]),
            .o_alu_b   (alu_b[k]),
            .o_alu_m   (alu_m[k]),
            .o_alu_cin (alu_cin[k]),
            .i_alu_r   (w_alu_r),
            .i_alu_of  (w_alu_of)
        );

        // Bench ALU with LAT registered stages
        always @(posedge clk or negedge rst_n[k]) begin
            if (!rst_n[k]) begin
                for (int i = 0; i < LAT; i++) pipe[i] <= '0;
            end else begin
                pipe[0] <= alu_f(alu_a[k], alu_b[k], alu_m[k], alu_cin[k]);
                for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
            end
        end
        assign w_alu_r  = pipe[LAT-1][W-1:0];
        assign w_alu_of = pipe[LAT-1][W];

        // Model: t counts cycles since grant; 0 means idle
        int           t;
        logic         e_last, e_owner, e_done0, e_done1, e_cin, e_of;
        logic [W-1:0] e_a, e_b, e_res;
        logic [OPW-1:0] e_m;

        function automatic logic pick(input logic r0, input logic r1, input logic last);
            if (r0 && r1) return ~last;
            return r1;
        endfunction

        always @(posedge clk or negedge rst_n[k]) begin
            if (!rst_n[k]) begin
                t <= 0; e_last <= 1'b1; e_owner <= 1'b0; e_done0 <= 1'b0; e_done1 <= 1'b0;
                e_a <= '0; e_b <= '0; e_m <= '0; e_cin <= 1'b0; e_res <= '0; e_of <= 1'b0;
            end else if (t == 0) begin
                if (req0[k] || req1[k]) begin
                    e_owner <= pick(req0[k], req1[k], e_last);
                    e_a   <= pick(req0[k], req1[k], e_last) ? a1[k]   : a0[k];
                    e_b   <= pick(req0[k], req1[k], e_last) ? b1[k]   : b0[k];
                    e_m   <= pick(req0[k], req1[k], e_last) ? m1[k]   : m0[k];
                    e_cin <= pick(req0[k], req1[k], e_last) ? cin1[k] : cin0[k];
                    t <= 1;
                end
            end else if (t == LAT + 1) begin
                {e_of, e_res} <= alu_f(e_a, e_b, e_m, e_cin);
                e_done0 <= ~e_owner;
                e_done1 <= e_owner;
                e_last  <= e_owner;
                t <= LAT + 2;
            end else if (t == LAT + 2) begin
                e_done0 <= 1'b0;
                e_done1 <= 1'b0;
                t <= 0;
            end else begin
                t <= t + 1;
            end
        end

        always @(negedge clk) begin
            if (rst_n[k]) begin
                chk($sformatf("L%0d busy", LAT),    32'(busy[k]),    32'(t != 0));
                chk($sformatf("L%0d done0", LAT),   32'(done0[k]),   32'(e_done0));
                chk($sformatf("L%0d done1", LAT),   32'(done1[k]),   32'(e_done1));
                chk($sformatf("L%0d owner", LAT),   32'(owner[k]),   32'(e_owner));
                chk($sformatf("L%0d res", LAT),     32'(res[k]),     32'(e_res));
                chk($sformatf("L%0d res_of", LAT),  32'(res_of[k]),  32'(e_of));
                chk($sformatf("L%0d alu_a", LAT),   32'(alu_a[k]),   32'(e_a));
                chk($sformatf("L%0d alu_b", LAT),   32'(alu_b[k]),   32'(e_b));
                chk($sformatf("L%0d alu_m", LAT),   32'(alu_m[k]),   32'(e_m));
                chk($sformatf("L%0d alu_cin", LAT), 32'(alu_cin[k]), 32'(e_cin));
                chk($sformatf("L%0d done excl", LAT), 32'(done0[k] & done1[k]), 32'(0));
            end
        end
    end

    // Idle ports get random operands so outputs must not follow unrequested inputs
    always @(negedge clk) begin
        #2;
        for (int k = 0; k < 2; k++) begin
            if (!req0[k]) begin
                a0[k] = W'($urandom); b0[k] = W'($urandom);
                m0[k] = OPW'($urandom); cin0[k] = 1'($urandom);
            end
            if (!req1[k]) begin
                a1[k] = W'($urandom); b1[k] = W'($urandom);
                m1[k] = OPW'($urandom); cin1[k] = 1'($urandom);
            end
        end
    end

    task automatic chk_zero(input int k, input string tag);
        chk({tag, " busy"},    32'(busy[k]),    0);
        chk({tag, " done0"},   32'(done0[k]),   0);
        chk({tag, " done1"},   32'(done1[k]),   0);
        chk({tag, " owner"},   32'(owner[k]),   0);
        chk({tag, " res"},     32'(res[k]),     0);
        chk({tag, " res_of"},  32'(res_of[k]),  0);
        chk({tag, " alu_a"},   32'(alu_a[k]),   0);
        chk({tag, " alu_b"},   32'(alu_b[k]),   0);
        chk({tag, " alu_m"},   32'(alu_m[k]),   0);
        chk({tag, " alu_cin"}, 32'(alu_cin[k]), 0);
    endtask

    task automatic wait_done(input int k, input logic port);
        int  n = 0;
        logic seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            seen = port ? done1[k] : done0[k];
        end
        chk($sformatf("wait done inst%0d port%0d", k, port), 32'(seen), 1);
    endtask

    task automatic wait_any(input int k, output logic port);
        int  n = 0;
        logic seen = 1'b0;
        port = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            seen = done0[k] | done1[k];
        end
        port = done1[k];
        chk($sformatf("wait any done inst%0d", k), 32'(seen), 1);
    endtask

    initial begin
        logic p;
        int   prev;
        prev = 0;
        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b0; req0[k] = 1'b0; req1[k] = 1'b0;
            a0[k] = '0; b0[k] = '0; m0[k] = '0; cin0[k] = 1'b0;
            a1[k] = '0; b1[k] = '0; m1[k] = '0; cin1[k] = 1'b0;
        end
        repeat (2) @(negedge clk);
        chk_zero(0, "rst L1");
        chk_zero(1, "rst L3");
        #1 rst_n[0] = 1'b1; rst_n[1] = 1'b1;

        // single request, port 0, add 1111+0001
        @(negedge clk); #1;
        a0[0] = 4'b1111; b0[0] = 4'b0001; m0[0] = 4'b0000; cin0[0] = 1'b0; req0[0] = 1'b1;
        @(negedge clk);
        chk("single alu_m E0", 32'(alu_m[0]), 0);
        chk("single alu_a E0", 32'(alu_a[0]), 32'hF);
        chk("single busy E0", 32'(busy[0]), 1);
        @(negedge clk);
        chk("single done0 E1", 32'(done0[0]), 0);
        @(negedge clk);
        chk("single done0 E2", 32'(done0[0]), 1);
        chk("single res", 32'(res[0]), 0);
        chk("single res_of", 32'(res_of[0]), 1);
        #1 req0[0] = 1'b0;
        @(negedge clk);
        chk("single done0 E3", 32'(done0[0]), 0);
        chk("single idle E3", 32'(busy[0]), 0);

        // reset pulse so the tie sees last=1 again
        #1 rst_n[0] = 1'b0;
        #1 chk_zero(0, "midrst L1");
        @(negedge clk); #1 rst_n[0] = 1'b1;
        chk("post rst busy", 32'(busy[0]), 0);

        // tie: port 0 subtract, port 1 AND
        @(negedge clk); #1;
        a0[0] = 4'b1111; b0[0] = 4'b1001; m0[0] = 4'b0001; cin0[0] = 1'b0;
        a1[0] = 4'b0111; b1[0] = 4'b1100; m1[0] = 4'b0011; cin1[0] = 1'b0;
        req0[0] = 1'b1; req1[0] = 1'b1;
        @(negedge clk);
        chk("tie first alu_m", 32'(alu_m[0]), 32'h1);
        chk("tie first owner", 32'(owner[0]), 0);
        wait_done(0, 1'b0);
        chk("tie port0 res", 32'(res[0]), 32'h6);
        #1 req0[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("tie second alu_m", 32'(alu_m[0]), 32'h3);
        chk("tie second owner", 32'(owner[0]), 1);
        wait_done(0, 1'b1);
        chk("tie port1 res", 32'(res[0]), 32'h4);
        chk("tie port1 res_of", 32'(res_of[0]), 0);
        #1 req1[0] = 1'b0;

        // fairness: both ports re-request after every done
        @(negedge clk); #1;
        a0[0] = 4'd1; b0[0] = 4'd2; m0[0] = 4'd0; cin0[0] = 1'b0;
        a1[0] = 4'd4; b1[0] = 4'd8; m1[0] = 4'd2; cin1[0] = 1'b0;
        req0[0] = 1'b1; req1[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_any(0, p);
            chk($sformatf("fair grant %0d", i), 32'(p), 32'(i % 2));
            if (i > 0) chk($sformatf("fair spacing %0d", i), 32'(cyc - prev), 4);
            prev = cyc;
            #1;
            if (i == 3) begin
                req0[0] = 1'b0; req1[0] = 1'b0;
            end else if (p) begin
                req1[0] = 1'b0;
            end else begin
                req0[0] = 1'b0;
            end
            if (i < 3) begin
                @(negedge clk); #1;
                if (p) begin
                    a1[0] = W'(i + 5); b1[0] = W'(3 * i); m1[0] = 4'd1; cin1[0] = 1'b1; req1[0] = 1'b1;
                end else begin
                    a0[0] = W'(i + 9); b0[0] = W'(7 * i); m0[0] = 4'd0; cin0[0] = 1'b1; req0[0] = 1'b1;
                end
            end
        end

        // abort: reset during RUN of a port 1 operation
        @(negedge clk); @(negedge clk); #1;
        a1[0] = 4'b0011; b1[0] = 4'b0100; m1[0] = 4'b0010; cin1[0] = 1'b0; req1[0] = 1'b1;
        @(negedge clk);
        chk("abort busy RUN", 32'(busy[0]), 1);
        chk("abort owner RUN", 32'(owner[0]), 1);
        #1 rst_n[0] = 1'b0;
        #1 chk_zero(0, "abort L1");
        @(negedge clk); #1 rst_n[0] = 1'b1;
        wait_done(0, 1'b1);
        chk("abort regrant res", 32'(res[0]), 32'h7);
        chk("abort regrant owner", 32'(owner[0]), 1);
        #1 req1[0] = 1'b0;

        // ALU_LAT=3, port 1: 0101+0011+1
        @(negedge clk); #1;
        a1[1] = 4'b0101; b1[1] = 4'b0011; m1[1] = 4'b0000; cin1[1] = 1'b1; req1[1] = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            chk($sformatf("lat3 done1 n%0d", n), 32'(done1[1]), 32'(n == 5));
            chk($sformatf("lat3 alu_a n%0d", n), 32'(alu_a[1]), 32'h5);
        end
        chk("lat3 res", 32'(res[1]), 32'h9);
        chk("lat3 res_of", 32'(res_of[1]), 0);
        #1 req1[1] = 1'b0;
        @(negedge clk);
        chk("lat3 done1 fall", 32'(done1[1]), 0);
        chk("lat3 alu_a held", 32'(alu_a[1]), 32'h5);
        chk("lat3 alu_m held", 32'(alu_m[1]), 0);

        // ALU_LAT=3, port 0 xor-default opcode
        @(negedge clk); #1;
        a0[1] = 4'b0010; b0[1] = 4'b0010; m0[1] = 4'b0100; cin0[1] = 1'b0; req0[1] = 1'b1;
        wait_done(1, 1'b0);
        chk("lat3 p0 res", 32'(res[1]), 0);
        chk("lat3 p0 res_of", 32'(res_of[1]), 1);
        #1 req0[1] = 1'b0;

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
